// File: rtl/bpsk_frame_ctrl_if.sv
// Byte-source / modulator-side signal bundle for bpsk_frame_ctrl.
// master: byte source + frame requester; slave: the frame controller.
interface bpsk_frame_ctrl_if;
  logic       start;
  logic [4:0] len;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       tx_bit;
  logic       tx_en;
  logic       bit_strobe;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output start, len, byte_in, byte_valid,
    input  byte_ready, tx_bit, tx_en, bit_strobe, busy, done, underrun
  );

  modport slave (
    input  start, len, byte_in, byte_valid,
    output byte_ready, tx_bit, tx_en, bit_strobe, busy, done, underrun
  );
endinterface

// File: rtl/bpsk_frame_ctrl.sv
// BPSK frame sequencer: preamble, sync word, LEN payload bytes (valid/ready
// pulled, one-byte prefetch) and optional CRC-8, as an NRZ stream with one
// bit per BIT_PERIOD clocks.
// Optional feature macro: BPSK_CRC8_EN (CRC-8 poly 0x07 byte after payload).
module bpsk_frame_ctrl #(
  parameter int          BIT_PERIOD    = 1200,
  parameter int          CARRIER_DIV   = 120,
  parameter int          PREAMBLE_BITS = 16,
  parameter logic [7:0]  SYNC_WORD     = 8'b10110010
) (
  input logic              clk,
  input logic              rst,
  bpsk_frame_ctrl_if.slave bus
);

  localparam int             TW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0]  TMAX     = TW'(BIT_PERIOD - 1);
  localparam logic [7:0]     PRE_LAST = 8'(PREAMBLE_BITS - 1);

  // Bit edges must land on carrier cycle boundaries or the modulator
  // produces a partial carrier period at every bit change.
  generate
    if ((BIT_PERIOD % (2 * CARRIER_DIV)) != 0) begin : g_bad_period
      $error("BIT_PERIOD must be a multiple of 2*CARRIER_DIV");
    end
    if ((PREAMBLE_BITS < 2) || (PREAMBLE_BITS > 255)) begin : g_bad_pre
      $error("PREAMBLE_BITS must be in 2..255");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_PAY,
`ifdef BPSK_CRC8_EN
    S_CRC,
`endif
    S_FIN
  } state_t;

  state_t         state, state_n;
  logic [TW-1:0]  timer;
  logic [7:0]     bit_cnt;
  logic [4:0]     len_q;
  logic [4:0]     acc_cnt;    // bytes accepted over the handshake
  logic [4:0]     load_cnt;   // bytes moved into the shifter
  logic [7:0]     hold_q;
  logic           hold_v;
  logic [7:0]     shift_q;
  logic           und_q;

  logic           tx_en_c;
  logic           strobe;
  logic           ready;
  logic           xfer;
  logic           avail;
  logic [7:0]     avail_byte;
  logic           bytes_left;
  logic           load;
  logic           und_set;

`ifdef BPSK_CRC8_EN
  logic [7:0]     crc_q;

  // Byte-at-a-time CRC-8, poly 0x07, MSB first (matches transmit order).
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  assign tx_en_c    = (state == S_PRE) || (state == S_SYNC) || (state == S_PAY)
`ifdef BPSK_CRC8_EN
                      || (state == S_CRC)
`endif
                      ;
  assign strobe     = tx_en_c && (timer == TMAX);
  assign ready      = !hold_v && (acc_cnt < len_q) &&
                      ((state == S_PRE) || (state == S_SYNC) || (state == S_PAY));
  assign xfer       = ready && bus.byte_valid;
  // A byte arriving on the boundary edge counts as present.
  assign avail      = hold_v || xfer;
  assign avail_byte = hold_v ? hold_q : bus.byte_in;
  assign bytes_left = load_cnt < len_q;

  // Next-state logic and byte-boundary decisions.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    und_set = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_n = S_PRE;
      S_PRE:  if (strobe && bit_cnt == PRE_LAST) state_n = S_SYNC;
      S_SYNC, S_PAY: begin
        if (strobe && bit_cnt == 8'd7) begin
          if (bytes_left) begin
            if (avail) begin
              state_n = S_PAY;
              load    = 1'b1;
            end else begin
              state_n = S_FIN;
              und_set = 1'b1;
            end
          end else begin
`ifdef BPSK_CRC8_EN
            state_n = S_CRC;
`else
            state_n = S_FIN;
`endif
          end
        end
      end
`ifdef BPSK_CRC8_EN
      S_CRC:  if (strobe && bit_cnt == 8'd7) state_n = S_FIN;
`endif
      S_FIN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register, bit timing and payload datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      len_q    <= '0;
      acc_cnt  <= '0;
      load_cnt <= '0;
      hold_q   <= '0;
      hold_v   <= 1'b0;
      shift_q  <= '0;
      und_q    <= 1'b0;
`ifdef BPSK_CRC8_EN
      crc_q    <= '0;
`endif
    end else begin
      state <= state_n;

      if (state == S_IDLE) begin
        // Everything restarts here so the frame begins with timer 0.
        timer    <= '0;
        bit_cnt  <= '0;
        acc_cnt  <= '0;
        load_cnt <= '0;
        hold_v   <= 1'b0;
        und_q    <= 1'b0;
`ifdef BPSK_CRC8_EN
        crc_q    <= '0;
`endif
        if (bus.start) len_q <= bus.len;
      end else begin
        if (tx_en_c) timer <= strobe ? '0 : timer + 1'b1;

        // Outside the preamble bit 7 always ends a byte.
        if (strobe)
          bit_cnt <= ((state_n != state) || (state != S_PRE && bit_cnt == 8'd7))
                     ? 8'd0 : bit_cnt + 8'd1;

        if (und_set) und_q <= 1'b1;

        if (xfer) acc_cnt <= acc_cnt + 5'd1;

        if (load) hold_v <= 1'b0;
        else if (xfer) begin
          hold_q <= bus.byte_in;
          hold_v <= 1'b1;
        end

        if (load) begin
          shift_q  <= avail_byte;
          load_cnt <= load_cnt + 5'd1;
`ifdef BPSK_CRC8_EN
          crc_q    <= crc8_byte(crc_q, avail_byte);
`endif
        end
`ifdef BPSK_CRC8_EN
        else if (state_n == S_CRC && state != S_CRC) shift_q <= crc_q;
        else if (strobe && (state == S_PAY || state == S_CRC)) shift_q <= shift_q << 1;
`else
        else if (strobe && state == S_PAY) shift_q <= shift_q << 1;
`endif
      end
    end
  end

  // Bit source selection by frame section.
  always_comb begin
    bus.tx_bit = 1'b0;
    case (state)
      S_PRE:  bus.tx_bit = ~bit_cnt[0];
      S_SYNC: bus.tx_bit = SYNC_WORD[3'd7 - bit_cnt[2:0]];
      S_PAY:  bus.tx_bit = shift_q[7];
`ifdef BPSK_CRC8_EN
      S_CRC:  bus.tx_bit = shift_q[7];
`endif
      default: bus.tx_bit = 1'b0;
    endcase
  end

  assign bus.tx_en      = tx_en_c;
  assign bus.bit_strobe = strobe;
  assign bus.byte_ready = ready;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_FIN);
  assign bus.underrun   = (state == S_FIN) && und_q;

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// Scoreboard bench for bpsk_frame_ctrl: stimulus pushes expected bits and
// end-of-frame records; a forked monitor pops them on bit_strobe / done.
// BIT_PERIOD=8, PREAMBLE_BITS=4; CARRIER_DIV=2 keeps the alignment rule valid.
module tb_bpsk_frame_ctrl;
  localparam int BP  = 8;
  localparam int PRE = 4;

  typedef struct { int nbits; bit und; } done_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bpsk_frame_ctrl_if bus();

  bpsk_frame_ctrl #(.BIT_PERIOD(BP), .CARRIER_DIV(2), .PREAMBLE_BITS(PRE),
                    .SYNC_WORD(8'b10110010))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  bit        exp_bits[$];
  done_rec_t exp_done[$];

  function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Expected frame: nb bytes actually sent (b0, b1), und = aborted for data.
  task automatic push_frame(input int nb, input logic [7:0] b0, input logic [7:0] b1, input bit und);
    logic [7:0] sw;
    logic [7:0] crc;
    logic [7:0] b;
    done_rec_t  r;
    int         n;
    sw  = 8'b10110010;
    crc = 8'h00;
    n   = 0;
    for (int i = 0; i < PRE; i++) begin exp_bits.push_back((i % 2) == 0); n++; end
    for (int i = 7; i >= 0; i--) begin exp_bits.push_back(sw[i]); n++; end
    for (int k = 0; k < nb; k++) begin
      b = (k == 0) ? b0 : b1;
      for (int i = 7; i >= 0; i--) begin exp_bits.push_back(b[i]); n++; end
      crc = crc_bits(crc, b);
    end
`ifdef BPSK_CRC8_EN
    if (!und) for (int i = 7; i >= 0; i--) begin exp_bits.push_back(crc[i]); n++; end
`endif
    r.nbits = n;
    r.und   = und;
    exp_done.push_back(r);
  endtask

  task automatic monitor_loop();
    bit run_en = 0, strobe_d = 0, bit_val = 0, glitch = 0, e;
    int hold_cnt = 0, nstrobe = 0;
    done_rec_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_en = 0; strobe_d = 0; nstrobe = 0;
      end else begin
        if (bus.tx_en) begin
          if (!run_en || strobe_d) begin hold_cnt = 1; bit_val = bus.tx_bit; glitch = 0; end
          else begin hold_cnt++; if (bus.tx_bit !== bit_val) glitch = 1; end
        end
        if (bus.bit_strobe) begin
          checks++;
          if (exp_bits.size() == 0) begin
            errors++;
            $display("FAIL bit_unexpected: strobe #%0d with tx_bit=%b, required no strobe", nstrobe, bus.tx_bit);
          end else begin
            e = exp_bits.pop_front();
            if (bus.tx_bit !== e || hold_cnt != BP || glitch || bus.tx_en !== 1'b1) begin
              errors++;
              $display("FAIL bit[%0d]: tx_bit=%b held=%0d glitch=%b tx_en=%b, required tx_bit=%b held=%0d",
                       nstrobe, bus.tx_bit, hold_cnt, glitch, bus.tx_en, e, BP);
            end
          end
          nstrobe++;
        end
        if (bus.done) begin
          checks++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: done with %0d bits, required no done", nstrobe);
          end else begin
            r = exp_done.pop_front();
            if (bus.underrun !== r.und || nstrobe != r.nbits || !strobe_d ||
                bus.tx_en !== 1'b0 || bus.tx_bit !== 1'b0 || bus.busy !== 1'b1) begin
              errors++;
              $display("FAIL done: underrun=%b bits=%0d prev_strobe=%b tx_en=%b tx_bit=%b busy=%b, required underrun=%b bits=%0d prev_strobe=1 tx_en=0 tx_bit=0 busy=1",
                       bus.underrun, nstrobe, strobe_d, bus.tx_en, bus.tx_bit, bus.busy, r.und, r.nbits);
            end
          end
          nstrobe = 0;
        end else if (bus.underrun) begin
          checks++; errors++;
          $display("FAIL underrun_without_done: underrun=1, required 0");
        end
        run_en   = bus.tx_en;
        strobe_d = bus.bit_strobe;
      end
    end
  endtask

  task automatic do_start(input logic [4:0] l, input int hold);
    @(negedge clk);
    bus.len   = l;
    bus.start = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] b0, input logic [7:0] b1);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.byte_in    = (i == 0) ? b0 : b1;
      bus.byte_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 2000 && !ok; k++) begin
        @(negedge clk);
        if (bus.byte_ready) ok = 1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL byte_accept[%0d]: byte_ready stayed 0, required 1 within 2000 clk", i);
      end
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done=0, required done within 2000 clk", name);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({bus.tx_bit, bus.tx_en, bus.byte_ready, bus.bit_strobe, bus.busy, bus.done, bus.underrun} !== 7'b0) begin
      errors++;
      $display("FAIL %s: outputs {tx_bit,tx_en,ready,strobe,busy,done,underrun}=%b, required 0000000", name,
               {bus.tx_bit, bus.tx_en, bus.byte_ready, bus.bit_strobe, bus.busy, bus.done, bus.underrun});
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;
    fork monitor_loop(); join_none

    // 1: reset, then idle with no activity
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); check_idle("reset_idle"); end

    // 2: len=2, both bytes offered immediately
    push_frame(2, 8'hA5, 8'h3C, 0);
    do_start(5'd2, 1);
    fork feed(2, 8'hA5, 8'h3C); wait_done("len2"); join

`ifdef BPSK_CRC8_EN
    // 3: len=1, byte 0x01 -> CRC 0x07 appended
    push_frame(1, 8'h01, 8'h00, 0);
    do_start(5'd1, 1);
    fork feed(1, 8'h01, 8'h00); wait_done("crc"); join
`endif

    // 4: len=2, second byte withheld -> underrun abort
    push_frame(1, 8'hA5, 8'h00, 1);
    do_start(5'd2, 1);
    fork feed(1, 8'hA5, 8'h00); wait_done("underrun"); join

    // 5: reset during SYNC bit 3, then a full fresh frame
    push_frame(0, 8'h00, 8'h00, 0);
    do_start(5'd0, 1);
    repeat (PRE * BP + 3 * BP + 3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("reset_mid_frame");
    exp_bits.delete();
    exp_done.delete();
    rst = 1'b0;
    push_frame(1, 8'h5A, 8'h00, 0);
    do_start(5'd1, 1);
    fork feed(1, 8'h5A, 8'h00); wait_done("after_reset"); join

    // 6: len=0, start held 3 clk, re-pulsed mid-frame and on the done cycle
    push_frame(0, 8'h00, 8'h00, 0);
    do_start(5'd0, 3);
    repeat (20) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("len0");
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done: busy=%b, required 0", bus.busy);
    end
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    check_idle("post_len0_idle");

    checks++;
    if (exp_bits.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bits and %0d done records left, required 0 and 0",
               exp_bits.size(), exp_done.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
